// File: rtl/rr_mux.sv
// rr_mux: registered N-channel select mux with fixed one-hot or round-robin arbitration
// and valid/ready handshakes on every input channel and on the output.
module rr_mux #(
    parameter int WIDTH = 4,
    parameter int NUM_CH = 3,
    localparam int CH_W = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic [NUM_CH-1:0]       sel,
    input  logic                    rr_en,
    output logic [WIDTH-1:0]        mux_op,
    output logic                    op_valid,
    input  logic                    op_ready,
    output logic [CH_W-1:0]         op_ch,
    output logic                    sel_err
);
    logic [WIDTH-1:0] data_q, data_d;
    logic [CH_W-1:0]  ch_q, ch_d, ptr_q, ptr_d;
    logic             valid_q, valid_d, err_q, err_d;
    logic             free, grant, sel_ok, fix_hit, rr_hit;
    logic [CH_W-1:0]  g, fix_g, rr_g;
    int               rr_j;

    always_comb begin
        fix_g = '0;
        rr_g = '0;
        rr_hit = 1'b0;
        rr_j = 0;
        sel_ok = $onehot(sel);
        for (int i = 0; i < NUM_CH; i++)
            if (sel[i]) fix_g = CH_W'(i);
        fix_hit = sel_ok && in_valid[fix_g];
        // Scan from the farthest offset down so the nearest valid channel wins.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            rr_j = int'(ptr_q) + i;
            if (rr_j >= NUM_CH) rr_j = rr_j - NUM_CH;
            if (in_valid[CH_W'(rr_j)]) begin
                rr_hit = 1'b1;
                rr_g = CH_W'(rr_j);
            end
        end
        free = !valid_q || op_ready;
        grant = free && (rr_en ? rr_hit : fix_hit);
        g = rr_en ? rr_g : fix_g;
        in_ready = (grant && !rst) ? (NUM_CH'(1) << g) : '0;
        valid_d = free ? grant : valid_q;
        data_d = grant ? in_data[g*WIDTH +: WIDTH] : data_q;
        ch_d = grant ? g : ch_q;
        ptr_d = (grant && rr_en) ? ((g == CH_W'(NUM_CH - 1)) ? '0 : g + 1'b1) : ptr_q;
        err_d = err_q || (!rr_en && !sel_ok && |in_valid);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            ch_q <= '0;
            ptr_q <= '0;
            valid_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            data_q <= data_d;
            ch_q <= ch_d;
            ptr_q <= ptr_d;
            valid_q <= valid_d;
            err_q <= err_d;
        end
    end

    assign mux_op = data_q;
    assign op_valid = valid_q;
    assign op_ch = ch_q;
    assign sel_err = err_q;
endmodule

// File: tb/tb_rr_mux.sv
// tb_rr_mux: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_rr_mux;
    localparam int W = 4;
    localparam int N = 3;
    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_ready;
    logic [N-1:0]   sel = '0;
    logic           rr_en = 1'b0;
    logic [W-1:0]   mux_op;
    logic           op_valid;
    logic           op_ready = 1'b1;
    logic [1:0]     op_ch;
    logic           sel_err;
    int checks = 0;
    int failures = 0;
    int m_ptr, m_ch;
    logic [W-1:0] m_data;
    logic m_valid, m_err;

    rr_mux #(.WIDTH(W), .NUM_CH(N)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .rr_en(rr_en), .mux_op(mux_op), .op_valid(op_valid), .op_ready(op_ready),
        .op_ch(op_ch), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    // Spec-level choice of the winning channel for the present inputs, -1 if none.
    function automatic int exp_grant();
        if (m_valid && !op_ready) return -1;
        if (rr_en) begin
            for (int k = 0; k < N; k++)
                if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
            return -1;
        end
        if ($countones(sel) == 1 && (sel & in_valid) != 0) return $clog2(sel);
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_ch = 0; m_data = '0; m_valid = 1'b0; m_err = 1'b0;
    endtask

    task automatic tick();
        int g;
        logic fr;
        g = exp_grant();
        fr = !m_valid || op_ready;
        if (!rr_en && $countones(sel) != 1 && in_valid != 0) m_err = 1'b1;
        @(posedge clk);
        if (fr) m_valid = (g >= 0);
        if (g >= 0) begin
            m_data = in_data[g*W +: W];
            m_ch = g;
            if (rr_en) m_ptr = (g + 1) % N;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        in_valid = 3'b111;
        sel = 3'b001;
        #3;
        checks++; if (op_valid !== 1'b0) begin failures++; $display("FAIL reset op_valid got=%b exp=0", op_valid); end
        checks++; if (mux_op !== 4'd0) begin failures++; $display("FAIL reset mux_op got=%h exp=0", mux_op); end
        checks++; if (op_ch !== 2'd0) begin failures++; $display("FAIL reset op_ch got=%0d exp=0", op_ch); end
        checks++; if (sel_err !== 1'b0) begin failures++; $display("FAIL reset sel_err got=%b exp=0", sel_err); end
        checks++; if (in_ready !== 3'b000) begin failures++; $display("FAIL reset in_ready got=%b exp=000", in_ready); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_legacy();
        logic [N-1:0] sels [3] = '{3'b001, 3'b010, 3'b100};
        logic [W-1:0] exp_d [3] = '{4'b0001, 4'b0010, 4'b0100};
        in_data = {4'b0100, 4'b0010, 4'b0001};
        in_valid = 3'b111;
        op_ready = 1'b1;
        rr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sel = sels[i];
            tick();
            checks++; if (mux_op !== exp_d[i] || op_ch !== 2'(i) || op_valid !== 1'b1)
                begin failures++; $display("FAIL legacy[%0d] got=%b/%0d/%b exp=%b/%0d/1", i, mux_op, op_ch, op_valid, exp_d[i], i); end
            checks++; if (sel_err !== 1'b0) begin failures++; $display("FAIL legacy sel_err got=%b exp=0", sel_err); end
        end
    endtask

    task automatic test_illegal();
        logic ev;
        rr_en = 1'b0;
        in_valid = 3'b111;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            tick();
            ev = (s == 1) || (s == 2) || (s == 4);
            checks++; if (op_valid !== ev) begin failures++; $display("FAIL illegal sel=%0d op_valid got=%b exp=%b", s, op_valid, ev); end
            checks++; if (sel_err !== 1'b1) begin failures++; $display("FAIL illegal sel=%0d sel_err got=%b exp=1", s, sel_err); end
        end
    endtask

    task automatic test_rr_fair();
        do_reset();
        rr_en = 1'b1;
        in_valid = 3'b111;
        op_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (op_ch !== 2'(i % 3) || op_valid !== 1'b1)
                begin failures++; $display("FAIL rr_fair[%0d] op_ch got=%0d exp=%0d valid=%b", i, op_ch, i % 3, op_valid); end
        end
        in_valid = 3'b110;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (op_ch !== 2'(1 + i % 2) || op_valid !== 1'b1)
                begin failures++; $display("FAIL rr_pair[%0d] op_ch got=%0d exp=%0d", i, op_ch, 1 + i % 2); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        rr_en = 1'b1;
        in_valid = 3'b111;
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 3'b000) begin failures++; $display("FAIL bp in_ready got=%b exp=000", in_ready); end
            tick();
            checks++; if (mux_op !== 4'b0001 || op_ch !== 2'd0 || op_valid !== 1'b1)
                begin failures++; $display("FAIL bp hold got=%b/%0d/%b exp=0001/0/1", mux_op, op_ch, op_valid); end
        end
        op_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 3'b010) begin failures++; $display("FAIL bp release in_ready got=%b exp=010", in_ready); end
        tick();
        checks++; if (mux_op !== 4'b0010 || op_ch !== 2'd1) begin failures++; $display("FAIL bp next got=%b/%0d exp=0010/1", mux_op, op_ch); end
    endtask

    task automatic test_mid_reset();
        rr_en = 1'b0;
        sel = 3'b000;
        tick();
        rr_en = 1'b1;
        tick();
        checks++; if (op_valid !== 1'b1 || sel_err !== 1'b1) begin failures++; $display("FAIL midrst setup got=%b/%b exp=1/1", op_valid, sel_err); end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++; if (op_valid !== 1'b0 || mux_op !== 4'd0 || sel_err !== 1'b0)
            begin failures++; $display("FAIL midrst async got=%b/%h/%b exp=0/0/0", op_valid, mux_op, sel_err); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++; if (op_ch !== 2'd0 || mux_op !== 4'b0001) begin failures++; $display("FAIL midrst restart got=%0d/%b exp=0/0001", op_ch, mux_op); end
    endtask

    task automatic test_mode_switch();
        int exp_seq [3] = '{0, 2, 1};
        do_reset();
        in_valid = 3'b111;
        op_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rr_en = (i != 1);
            sel = 3'b100;
            tick();
            checks++; if (op_ch !== 2'(exp_seq[i]) || op_valid !== 1'b1)
                begin failures++; $display("FAIL mode[%0d] op_ch got=%0d exp=%0d", i, op_ch, exp_seq[i]); end
        end
    endtask

    task automatic test_random();
        int g;
        logic [N-1:0] er;
        for (int c = 0; c < 300; c++) begin
            in_data = N*W'($urandom);
            in_valid = N'($urandom);
            sel = N'($urandom);
            rr_en = ($urandom_range(0, 3) != 0);
            op_ready = ($urandom_range(0, 3) != 0);
            #1;
            g = exp_grant();
            er = (g >= 0) ? N'(1 << g) : '0;
            checks++; if (in_ready !== er) begin failures++; $display("FAIL rand[%0d] in_ready got=%b exp=%b", c, in_ready, er); end
            tick();
            checks++; if (op_valid !== m_valid || mux_op !== m_data || op_ch !== 2'(m_ch) || sel_err !== m_err)
                begin failures++; $display("FAIL rand[%0d] out got=%b/%h/%0d/%b exp=%b/%h/%0d/%b", c, op_valid, mux_op, op_ch, sel_err, m_valid, m_data, m_ch, m_err); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_legacy();
        test_illegal();
        test_rr_fair();
        test_backpressure();
        test_mid_reset();
        test_mode_switch();
        do_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
